timer_pwm: RTL and testbench

- Multi-channel PWM output stage directly downstream of the timer core.
- Consumes the core's live counter, active flag and match pulse, and drives per-channel PWM pins.
- Duty and polarity settings are double-buffered: a software load is committed only at a period boundary, or immediately while the timer is idle, so pins never glitch.
- Also emits a registered end-of-period pulse for the interrupt logic.

---
 rtl/timer_pwm.sv | 179 +++++++++++++++++
 tb/tb_timer_pwm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_pwm.sv
`default_nettype none
// =============================================================================
// Module   : timer_pwm
// Summary  : Double-buffered multi-channel PWM stage fed by the timer core.
//            Define TIMER_PWM_DEADTIME_EN for complementary outputs with dead time.
// Revision : 1.0 - initial release
// =============================================================================
module timer_pwm #(
    parameter int CHANNELS = 4,
    parameter int DEADTIME = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     timer_active,
    input  logic                     timer_match,
    input  logic [31:0]              timer_counter,
    input  logic [32*CHANNELS-1:0]   cfg_duty,
    input  logic [CHANNELS-1:0]      cfg_enable,
    input  logic [CHANNELS-1:0]      cfg_polarity,
    input  logic                     cfg_load,
    output logic                     load_pending,
    output logic                     period_end,
`ifdef TIMER_PWM_DEADTIME_EN
    output logic [CHANNELS-1:0]      pwm_out_n,
`endif
    output logic [CHANNELS-1:0]      pwm_out
);

    if (CHANNELS < 1 || CHANNELS > 8 || DEADTIME < 1 || DEADTIME > 255) begin : g_param_check
        $error("timer_pwm: CHANNELS or DEADTIME out of range");
    end

    logic [32*CHANNELS-1:0] r_duty_act;
    logic [32*CHANNELS-1:0] r_duty_shd;
    logic [CHANNELS-1:0]    r_en_act;
    logic [CHANNELS-1:0]    r_en_shd;
    logic [CHANNELS-1:0]    r_pol_act;
    logic [CHANNELS-1:0]    r_pol_shd;
    logic                   r_load_pending;
    logic                   r_period_end;
    logic                   w_commit;
    logic [CHANNELS-1:0]    w_raw;

    // Settings may only change at a period boundary or while the timer is idle.
    assign w_commit = timer_match | ~timer_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_act     <= '0;
            r_duty_shd     <= '0;
            r_en_act       <= '0;
            r_en_shd       <= '0;
            r_pol_act      <= '0;
            r_pol_shd      <= '0;
            r_load_pending <= 1'b0;
        end else if (cfg_load && w_commit) begin
            r_duty_act     <= cfg_duty;
            r_en_act       <= cfg_enable;
            r_pol_act      <= cfg_polarity;
            r_load_pending <= 1'b0;
        end else if (cfg_load) begin
            r_duty_shd     <= cfg_duty;
            r_en_shd       <= cfg_enable;
            r_pol_shd      <= cfg_polarity;
            r_load_pending <= 1'b1;
        end else if (w_commit && r_load_pending) begin
            r_duty_act     <= r_duty_shd;
            r_en_act       <= r_en_shd;
            r_pol_act      <= r_pol_shd;
            r_load_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_end <= 1'b0;
        end else begin
            r_period_end <= timer_match & timer_active;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_raw
        assign w_raw[i] = r_en_act[i] & timer_active &
                          (timer_counter < r_duty_act[32*i +: 32]);
    end

    assign load_pending = r_load_pending;
    assign period_end   = r_period_end;

`ifdef TIMER_PWM_DEADTIME_EN
    localparam logic [1:0] c_low_side    = 2'd0;
    localparam logic [1:0] c_dead        = 2'd1;
    localparam logic [1:0] c_high_side   = 2'd2;
    localparam logic [7:0] c_dead_cycles = 8'(DEADTIME);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_deadtime
        logic [1:0] r_state;
        logic [1:0] w_state_nxt;
        logic [7:0] r_cnt;
        logic [7:0] w_cnt_nxt;
        logic       r_target;
        logic       w_target_nxt;
        logic       w_p;
        logic       w_n;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= c_dead;
                r_cnt    <= c_dead_cycles;
                r_target <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_target <= w_target_nxt;
            end
        end

        // r_target is the side to assert once the dead window expires.
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_target_nxt = r_target;
            case (r_state)
                c_low_side: begin
                    if (w_raw[i]) begin
                        w_state_nxt  = c_dead;
                        w_cnt_nxt    = c_dead_cycles;
                        w_target_nxt = 1'b1;
                    end
                end
                c_high_side: begin
                    if (!w_raw[i]) begin
                        w_state_nxt  = c_dead;
                        w_cnt_nxt    = c_dead_cycles;
                        w_target_nxt = 1'b0;
                    end
                end
                c_dead: begin
                    if (w_raw[i] != r_target) begin
                        w_cnt_nxt    = c_dead_cycles;
                        w_target_nxt = w_raw[i];
                    end else if (r_cnt <= 8'd1) begin
                        w_state_nxt = r_target ? c_high_side : c_low_side;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt  = c_dead;
                    w_cnt_nxt    = c_dead_cycles;
                    w_target_nxt = w_raw[i];
                end
            endcase
        end

        always_comb begin
            w_p = (r_state == c_high_side) ^ r_pol_act[i];
            w_n = (r_state == c_low_side)  ^ r_pol_act[i];
        end

        assign pwm_out[i]   = w_p;
        assign pwm_out_n[i] = w_n;
    end
`else
    logic [CHANNELS-1:0] r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_raw ^ r_pol_act;
        end
    end

    assign pwm_out = r_pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_pwm.sv
`default_nettype none
// =============================================================================
// Module   : tb_timer_pwm
// Summary  : Directed self-checking bench for timer_pwm with a simple timer model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_timer_pwm;

    localparam int CHANNELS = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   timer_active;
    logic                   timer_match;
    logic [31:0]            timer_counter;
    logic [32*CHANNELS-1:0] cfg_duty;
    logic [CHANNELS-1:0]    cfg_enable;
    logic [CHANNELS-1:0]    cfg_polarity;
    logic                   cfg_load;
    logic                   load_pending;
    logic                   period_end;
    logic [CHANNELS-1:0]    pwm_out;
`ifdef TIMER_PWM_DEADTIME_EN
    logic [CHANNELS-1:0]    pwm_out_n;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cnt     = 0;
    int          cmp     = 9;
    bit          running = 1'b0;
    logic [31:0] pc;
    logic        pa;
    logic        pm;
    int          d;
    int          n_high;
    int          n_low;

    timer_pwm #(
        .CHANNELS (CHANNELS),
        .DEADTIME (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .timer_active  (timer_active),
        .timer_match   (timer_match),
        .timer_counter (timer_counter),
        .cfg_duty      (cfg_duty),
        .cfg_enable    (cfg_enable),
        .cfg_polarity  (cfg_polarity),
        .cfg_load      (cfg_load),
        .load_pending  (load_pending),
        .period_end    (period_end),
`ifdef TIMER_PWM_DEADTIME_EN
        .pwm_out_n     (pwm_out_n),
`endif
        .pwm_out       (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        n_tests++;
        assert (obsv === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
        end
    endtask

    task automatic drive();
        timer_active  = running;
        timer_counter = 32'(cnt);
        timer_match   = running && (cnt == cmp);
    endtask

    // pc/pa/pm hold the timer inputs of the cycle whose result is visible after the edge.
    task automatic tick();
        pc = timer_counter;
        pa = timer_active;
        pm = timer_match;
        @(posedge clk);
        #1;
        if (running) cnt = (cnt == cmp) ? 0 : cnt + 1;
        drive();
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_duty     = '0;
        cfg_enable   = '0;
        cfg_polarity = '0;
        cfg_load     = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pwm", pwm_out, 0);
        check("reset_pending", load_pending, 0);
        check("reset_period_end", period_end, 0);
`ifdef TIMER_PWM_DEADTIME_EN
        check("reset_pwm_n", pwm_out_n, 0);
`endif
        rst_n = 1'b1;

`ifndef TIMER_PWM_DEADTIME_EN
        // Idle load of duty 3 on ch0, then run: 3 high / 7 low per period.
        cfg_duty   = {32'd0, 32'd0, 32'd0, 32'd3};
        cfg_enable = 4'b0001;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("idleA_pending", load_pending, 0);
        running = 1'b1;
        cnt     = 0;
        drive();
        repeat (20) begin
            tick();
            check("dutyA_pwm", pwm_out, {3'b000, pc < 32'd3});
            check("dutyA_period_end", period_end, pm);
        end

        // Shadow load at counter=4; takes effect only after the match.
        repeat (4) tick();
        cfg_duty[31:0] = 32'd7;
        cfg_load       = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("shadowB_pending", load_pending, 1);
        check("shadowB_pwm_at_load", pwm_out, 0);
        d      = 3;
        n_high = 0;
        repeat (15) begin
            tick();
            check("shadowB_pwm", pwm_out, {3'b000, pc < 32'(d)});
            if (d == 7 && pwm_out[0]) n_high++;
            if (pm) d = 7;
            check("shadowB_pending_hold", load_pending, (d == 3));
        end
        check("shadowB_high_count", n_high, 7);

        // Load coincident with the match: applies from counter=0, no pending.
        repeat (9) tick();
        cfg_duty     = {32'd0, 32'd0, 32'd5, 32'd2};
        cfg_enable   = 4'b0011;
        cfg_polarity = 4'b0100;
        cfg_load     = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("matchC_pending", load_pending, 0);
        check("matchC_period_end", period_end, 1);
        check("matchC_pwm_last", pwm_out, 0);
        repeat (10) begin
            tick();
            check("matchC_pwm", pwm_out, {1'b0, 1'b1, pc < 32'd5, pc < 32'd2});
        end
        repeat (2) tick();
        cfg_polarity = 4'b1111;
        cfg_load     = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("haltC_pending_set", load_pending, 1);
        check("haltC_pwm_running", pwm_out, 4'b0110);
        running = 1'b0;
        drive();
        tick();
        check("haltC_pending_commit", load_pending, 0);
        check("haltC_pwm_idle_old_pol", pwm_out, 4'b0100);
        check("haltC_period_end", period_end, 0);
        tick();
        check("haltC_pwm_idle_new_pol", pwm_out, 4'b1111);

        // Idle commit of boundary duties: 0, >compare (inverted), =compare.
        cfg_duty     = {32'd0, 32'd9, 32'd15, 32'd0};
        cfg_enable   = 4'b0111;
        cfg_polarity = 4'b0010;
        cfg_load     = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("idleD_pending", load_pending, 0);
        check("idleD_pwm_old_pol", pwm_out, 4'b1111);
        tick();
        check("idleD_pwm_new_pol", pwm_out, 4'b0010);
        running = 1'b1;
        cnt     = 0;
        drive();
        repeat (20) begin
            tick();
            check("boundD_pwm", pwm_out, {1'b0, pc < 32'd9, 2'b00});
            check("boundD_period_end", period_end, pm);
        end

        // Asynchronous reset mid-period with an output high and a load pending.
        repeat (4) tick();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("resetE_pending_before", load_pending, 1);
        tick();
        check("resetE_pwm_before", pwm_out, 4'b0100);
        rst_n = 1'b0;
        #2;
        check("resetE_pwm", pwm_out, 0);
        check("resetE_pending", load_pending, 0);
        check("resetE_period_end", period_end, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            check("resetE_active_cleared", pwm_out, 0);
            check("resetE_period_end_after", period_end, pm);
        end
`else
        // Dead time 2, duty 5, period 10: each side high 3 cycles, never together.
        cfg_duty   = {32'd0, 32'd0, 32'd0, 32'd5};
        cfg_enable = 4'b0001;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("dtF_pending", load_pending, 0);
        repeat (3) tick();
        check("dtF_idle_p", pwm_out[0], 0);
        check("dtF_idle_n", pwm_out_n[0], 1);
        running = 1'b1;
        cnt     = 0;
        drive();
        n_high = 0;
        n_low  = 0;
        repeat (20) begin
            tick();
            check("dtF_p", pwm_out[0], (pc >= 32'd2 && pc <= 32'd4));
            check("dtF_n", pwm_out_n[0], (pc >= 32'd7));
            check("dtF_overlap", pwm_out[0] & pwm_out_n[0], 0);
            n_high += int'(pwm_out[0]);
            n_low  += int'(pwm_out_n[0]);
        end
        check("dtF_p_count", n_high, 6);
        check("dtF_n_count", n_low, 6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
